instruction_encode: RTL and testbench
=====================================

Name: instruction_encode

Overview:
Streaming RV32I instruction encoder: the write-side counterpart of the pipeline's instruction decoder. It takes an operation enum plus register and immediate fields, and emits the packed 32-bit instruction word with a byte address, for loading instruction memory. Its type one-hot uses the decoder's encoding, so a loader can round-trip words through the decoder for self-check. A small run FSM frames a program of N words.

Parameters:
ADDR_W, 32, width of out_addr / base_addr
CNT_W, 16, width of word count / err_count
BASE_DEFAULT, 0, reset value of address register

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run (ignored unless IDLE)
base_addr  in  ADDR_W  first byte address of run, sampled on start
count  in  CNT_W  number of words in run, sampled on start
in_valid  in  1  encode request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_op  in  6  operation enum (instr_pkg::op_e)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate, two's complement (U-type: 20-bit upper value)
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts word
out_word  out  32  packed instruction
out_addr  out  ADDR_W  byte address of out_word
out_type  out  6  R=100000 I=010000 S=001000 B=000100 J=000010 U=000001, loads/NOP=000000
busy  out  1  high in RUN
done  out  1  one-cycle pulse after last output handshake
err_count  out  CNT_W  number of requests rejected by range check (saturating)

Behaviour:
- Reset (async, reset_n low): state=IDLE; out_valid=0, out_word=0, out_type=0, out_addr=BASE_DEFAULT, busy=0, done=0, err_count=0, in_ready=0. Any partial run is abandoned; the held word is dropped.
- States: IDLE -> RUN on start (addr<=base_addr, remain<=count). count=0: IDLE -> DONE directly. RUN -> DONE on the output handshake that consumes the last word. DONE -> IDLE unconditionally; done=1 only in DONE.
- In RUN, in_ready = (accepted<count) && (!out_valid || out_ready). This gives a single output register with same-cycle pass-through on a simultaneous drain and accept.
- Latency: request accepted at edge N -> out_valid/out_word/out_type/out_addr valid after edge N. Outputs are held stable while out_valid&&!out_ready.
- out_addr starts at base_addr and advances by 4 on each output handshake, wrapping modulo 2^ADDR_W.
- Packing follows standard RV32I formats: R, I, S, B (imm[12|10:5] at 31:25, imm[4:1|11] at 11:7), U (in_imm[19:0] at 31:12), J (imm[20|10:1|11|19:12]).
- SRAI/SRA set funct7=0x20; SUB sets 0x20; SLLI/SRLI/SRAI place shamt=in_imm[4:0].
- JALR is I-format, opcode 1100111, funct3 0, type 010000. Loads emit type 000000. NOP op emits word 32'h00000000, type 000000.
- Ops: NOP, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, SB, SH, SW, JAL, LUI, AUIPC, ADDI, XORI, ORI, ANDI, SLLI, SRLI, SRAI, SLTI, SLTIU, LB, LH, LW, LBU, LHU, BEQ, BNE, BLT, BGE, BLTU, BGEU, JALR. Any other enum value is illegal.
- Illegal op: emits word 0 (decodes as NOP) with type 000000, still consumes one slot and address, and increments err_count.
- start during RUN/DONE: ignored. in_valid outside RUN: not accepted.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: a request fails if any of the following hold; it then emits word 0, type 000000, and err_count++ (saturating):
  - I/S imm outside -2048..2047
  - B imm outside -4096..4094, or odd
  - J imm outside -2^20..2^20-2, or odd
  - shamt imm outside 0..31
  - U imm[31:20]!=0
- Undefined: immediates are silently truncated to field width; err_count counts illegal ops only.

Decomposition:
- Package instr_pkg: op_e enum, opcode constants (OPC_R=0110011, OPC_I=0010011, OPC_LOAD=0000011, OPC_S=0100011, OPC_B=1100011, OPC_JAL=1101111, OPC_JALR=1100111, OPC_LUI=0110111, OPC_AUIPC=0010111), funct3/funct7 constants, type one-hot constants.
- Sub-module instr_pack: combinational op/fields -> {word, type, err}. The parent holds the FSM, handshake, address and counters.

Test Plan:
- start base=0x100 count=1; ADD rd=1 rs1=2 rs2=3 -> out_word=0x003100B3, type=100000, out_addr=0x100, done pulse after handshake.
- ADDI rd=5 rs1=0 imm=-1 -> 0xFFF00293, type=010000; SW rs1=2 rs2=8 imm=12 -> 0x00812623, type=001000.
- BEQ rs1=1 rs2=2 imm=8 -> 0x00208463, type=000100; count=2 run gives addrs 0x100, 0x104 then done.
- With IMM_RANGE_CHECK_EN: ADDI imm=2048 -> out_word=0, type=000000, err_count=1; without macro -> 0x80000013 (truncated), err_count=0.
- out_ready low 3 cycles with in_valid high -> word/addr stable, in_ready=0. Release -> back-to-back words one per cycle, no loss or duplication.
- reset_n low mid-run after 2 of 4 words -> all outputs at reset values immediately. New start base=0 -> first out_addr=0.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared RV32I encoding constants: op enum, opcodes, funct fields, decoder type one-hots.
package instr_pkg;

    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_SB, OP_SH, OP_SW, OP_JAL, OP_LUI, OP_AUIPC,
        OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JALR
    } op_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_B    = 3'd0, F3_H   = 3'd1, F3_W   = 3'd2, F3_BU   = 3'd4, F3_HU = 3'd5;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [5:0] TYPE_R    = 6'b100000;
    localparam logic [5:0] TYPE_I    = 6'b010000;
    localparam logic [5:0] TYPE_S    = 6'b001000;
    localparam logic [5:0] TYPE_B    = 6'b000100;
    localparam logic [5:0] TYPE_J    = 6'b000010;
    localparam logic [5:0] TYPE_U    = 6'b000001;
    localparam logic [5:0] TYPE_NONE = 6'b000000;

    typedef enum logic [3:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_LD, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
    } enc_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational op/fields -> packed RV32I word, decoder type one-hot and reject flag.
// IMM_RANGE_CHECK_EN rejects immediates that do not fit their field instead of truncating.
module instr_pack
    import instr_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic [5:0]  o_type,
    output logic        o_err
);

    enc_t        w_enc;
    logic        w_illegal;
    logic        w_range_bad;
    logic [31:0] w_word;
    logic [5:0]  w_type;

    always_comb begin
        w_enc     = enc_t'{FMT_NONE, 7'd0, 3'd0, F7_BASE};
        w_illegal = 1'b0;
        case (i_op)
            OP_NOP:   w_enc = enc_t'{FMT_NONE, 7'd0, 3'd0, F7_BASE};
            OP_ADD:   w_enc = enc_t'{FMT_R, OPC_R, F3_ADD, F7_BASE};
            OP_SUB:   w_enc = enc_t'{FMT_R, OPC_R, F3_ADD, F7_ALT};
            OP_SLL:   w_enc = enc_t'{FMT_R, OPC_R, F3_SLL, F7_BASE};
            OP_SLT:   w_enc = enc_t'{FMT_R, OPC_R, F3_SLT, F7_BASE};
            OP_SLTU:  w_enc = enc_t'{FMT_R, OPC_R, F3_SLTU, F7_BASE};
            OP_XOR:   w_enc = enc_t'{FMT_R, OPC_R, F3_XOR, F7_BASE};
            OP_SRL:   w_enc = enc_t'{FMT_R, OPC_R, F3_SR, F7_BASE};
            OP_SRA:   w_enc = enc_t'{FMT_R, OPC_R, F3_SR, F7_ALT};
            OP_OR:    w_enc = enc_t'{FMT_R, OPC_R, F3_OR, F7_BASE};
            OP_AND:   w_enc = enc_t'{FMT_R, OPC_R, F3_AND, F7_BASE};
            OP_SB:    w_enc = enc_t'{FMT_S, OPC_S, F3_B, F7_BASE};
            OP_SH:    w_enc = enc_t'{FMT_S, OPC_S, F3_H, F7_BASE};
            OP_SW:    w_enc = enc_t'{FMT_S, OPC_S, F3_W, F7_BASE};
            OP_JAL:   w_enc = enc_t'{FMT_J, OPC_JAL, 3'd0, F7_BASE};
            OP_LUI:   w_enc = enc_t'{FMT_U, OPC_LUI, 3'd0, F7_BASE};
            OP_AUIPC: w_enc = enc_t'{FMT_U, OPC_AUIPC, 3'd0, F7_BASE};
            OP_ADDI:  w_enc = enc_t'{FMT_I, OPC_I, F3_ADD, F7_BASE};
            OP_XORI:  w_enc = enc_t'{FMT_I, OPC_I, F3_XOR, F7_BASE};
            OP_ORI:   w_enc = enc_t'{FMT_I, OPC_I, F3_OR, F7_BASE};
            OP_ANDI:  w_enc = enc_t'{FMT_I, OPC_I, F3_AND, F7_BASE};
            OP_SLLI:  w_enc = enc_t'{FMT_SH, OPC_I, F3_SLL, F7_BASE};
            OP_SRLI:  w_enc = enc_t'{FMT_SH, OPC_I, F3_SR, F7_BASE};
            OP_SRAI:  w_enc = enc_t'{FMT_SH, OPC_I, F3_SR, F7_ALT};
            OP_SLTI:  w_enc = enc_t'{FMT_I, OPC_I, F3_SLT, F7_BASE};
            OP_SLTIU: w_enc = enc_t'{FMT_I, OPC_I, F3_SLTU, F7_BASE};
            OP_LB:    w_enc = enc_t'{FMT_LD, OPC_LOAD, F3_B, F7_BASE};
            OP_LH:    w_enc = enc_t'{FMT_LD, OPC_LOAD, F3_H, F7_BASE};
            OP_LW:    w_enc = enc_t'{FMT_LD, OPC_LOAD, F3_W, F7_BASE};
            OP_LBU:   w_enc = enc_t'{FMT_LD, OPC_LOAD, F3_BU, F7_BASE};
            OP_LHU:   w_enc = enc_t'{FMT_LD, OPC_LOAD, F3_HU, F7_BASE};
            OP_BEQ:   w_enc = enc_t'{FMT_B, OPC_B, F3_BEQ, F7_BASE};
            OP_BNE:   w_enc = enc_t'{FMT_B, OPC_B, F3_BNE, F7_BASE};
            OP_BLT:   w_enc = enc_t'{FMT_B, OPC_B, F3_BLT, F7_BASE};
            OP_BGE:   w_enc = enc_t'{FMT_B, OPC_B, F3_BGE, F7_BASE};
            OP_BLTU:  w_enc = enc_t'{FMT_B, OPC_B, F3_BLTU, F7_BASE};
            OP_BGEU:  w_enc = enc_t'{FMT_B, OPC_B, F3_BGEU, F7_BASE};
            OP_JALR:  w_enc = enc_t'{FMT_I, OPC_JALR, 3'd0, F7_BASE};
            default:  w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_word = 32'd0;
        w_type = TYPE_NONE;
        case (w_enc.fmt)
            FMT_R: begin
                w_word = {w_enc.f7, i_rs2, i_rs1, w_enc.f3, i_rd, w_enc.opc};
                w_type = TYPE_R;
            end
            FMT_I: begin
                w_word = {i_imm[11:0], i_rs1, w_enc.f3, i_rd, w_enc.opc};
                w_type = TYPE_I;
            end
            FMT_SH: begin
                w_word = {w_enc.f7, i_imm[4:0], i_rs1, w_enc.f3, i_rd, w_enc.opc};
                w_type = TYPE_I;
            end
            FMT_LD: w_word = {i_imm[11:0], i_rs1, w_enc.f3, i_rd, w_enc.opc};
            FMT_S: begin
                w_word = {i_imm[11:5], i_rs2, i_rs1, w_enc.f3, i_imm[4:0], w_enc.opc};
                w_type = TYPE_S;
            end
            FMT_B: begin
                w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_enc.f3,
                          i_imm[4:1], i_imm[11], w_enc.opc};
                w_type = TYPE_B;
            end
            FMT_U: begin
                w_word = {i_imm[19:0], i_rd, w_enc.opc};
                w_type = TYPE_U;
            end
            FMT_J: begin
                w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_enc.opc};
                w_type = TYPE_J;
            end
            default: ;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // A value fits an N-bit signed field when all bits from N-1 upward are sign copies.
    always_comb begin
        w_range_bad = 1'b0;
        case (w_enc.fmt)
            FMT_I, FMT_LD, FMT_S: w_range_bad = !((&i_imm[31:11]) || !(|i_imm[31:11]));
            FMT_B:  w_range_bad = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
            FMT_J:  w_range_bad = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
            FMT_SH: w_range_bad = |i_imm[31:5];
            FMT_U:  w_range_bad = |i_imm[31:20];
            default: w_range_bad = 1'b0;
        endcase
    end
`else
    logic w_unused_imm;
    assign w_unused_imm = ^i_imm[31:21];
    assign w_range_bad  = 1'b0;
`endif

    assign o_err  = w_illegal || w_range_bad;
    assign o_word = o_err ? 32'd0 : w_word;
    assign o_type = o_err ? TYPE_NONE : w_type;

endmodule

// File: rtl/instruction_encode.sv
// Streaming RV32I encoder framing an N-word run; a request appears on out_* one cycle after acceptance.
// One output register: in_ready drops while the held word is stalled. IMM_RANGE_CHECK_EN enables immediate rejection.
module instruction_encode
    import instr_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                CNT_W        = 16,
    parameter logic [ADDR_W-1:0] BASE_DEFAULT = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [5:0]        out_type,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count
);

    logic [31:0]       w_word;
    logic [5:0]        w_type;
    logic              w_err;
    logic              w_in_hs;
    logic              w_out_hs;

    state_e            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_accepted;
    logic [CNT_W-1:0]  r_left;
    logic [CNT_W-1:0]  r_err_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_out_valid;
    logic [31:0]       r_word;
    logic [5:0]        r_type;
    logic              r_busy;
    logic              r_done;

    instr_pack u_pack (
        .i_op   (in_op),
        .i_rd   (in_rd),
        .i_rs1  (in_rs1),
        .i_rs2  (in_rs2),
        .i_imm  (in_imm),
        .o_word (w_word),
        .o_type (w_type),
        .o_err  (w_err)
    );

    // Draining and refilling the output register in the same cycle keeps one word per cycle.
    assign in_ready = (r_state == ST_RUN) && (r_accepted < r_count) && (!r_out_valid || out_ready);
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_accepted  <= '0;
            r_left      <= '0;
            r_err_count <= '0;
            r_addr      <= BASE_DEFAULT;
            r_out_valid <= 1'b0;
            r_word      <= '0;
            r_type      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_count    <= count;
                        r_left     <= count;
                        r_accepted <= '0;
                        if (count == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_in_hs) begin
                        r_accepted <= r_accepted + CNT_W'(1);
                    end
                    if (w_out_hs) begin
                        r_addr <= r_addr + ADDR_W'(4);
                        r_left <= r_left - CNT_W'(1);
                        if (r_left == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_in_hs) begin
                r_out_valid <= 1'b1;
                r_word      <= w_word;
                r_type      <= w_type;
                if (w_err && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_word;
    assign out_type  = r_type;
    assign out_addr  = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instruction_encode.sv
// Randomized bench for instruction_encode against a table-driven RV32I reference model.
module tb_instruction_encode;
    import instr_pkg::*;

    localparam int K_ILL = 0, K_NOP = 1, K_R = 2, K_I = 3, K_SH = 4, K_LD = 5,
                   K_S = 6, K_B = 7, K_U = 8, K_J = 9;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        bit          has_exp;
        logic [31:0] ew;
        logic [5:0]  et;
    } req_t;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  t;
        logic [31:0] a;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic [5:0]  out_type;
    logic        busy, done;
    logic [15:0] err_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_err = 0;
    int          kind [64];
    logic [6:0]  t_opc [64];
    logic [2:0]  t_f3 [64];
    logic [6:0]  t_f7 [64];
    req_t        sq[$];
    exp_t        sb[$];
    logic [31:0] cur_base;
    int          pushed;

    always #5 clock = ~clock;

    instruction_encode dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr), .out_type(out_type),
        .busy(busy), .done(done), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tset(input op_e op, input int k, input logic [6:0] opc,
                        input logic [2:0] f3, input logic [6:0] f7);
        kind[int'(op)] = k; t_opc[int'(op)] = opc; t_f3[int'(op)] = f3; t_f7[int'(op)] = f7;
    endtask

    task automatic build_table();
        for (int i = 0; i < 64; i++) kind[i] = K_ILL;
        tset(OP_NOP, K_NOP, 7'h00, 0, 0);
        tset(OP_ADD, K_R, 7'h33, 0, 0);   tset(OP_SUB, K_R, 7'h33, 0, 7'h20);
        tset(OP_SLL, K_R, 7'h33, 1, 0);   tset(OP_SLT, K_R, 7'h33, 2, 0);
        tset(OP_SLTU, K_R, 7'h33, 3, 0);  tset(OP_XOR, K_R, 7'h33, 4, 0);
        tset(OP_SRL, K_R, 7'h33, 5, 0);   tset(OP_SRA, K_R, 7'h33, 5, 7'h20);
        tset(OP_OR, K_R, 7'h33, 6, 0);    tset(OP_AND, K_R, 7'h33, 7, 0);
        tset(OP_SB, K_S, 7'h23, 0, 0);    tset(OP_SH, K_S, 7'h23, 1, 0);
        tset(OP_SW, K_S, 7'h23, 2, 0);    tset(OP_JAL, K_J, 7'h6F, 0, 0);
        tset(OP_LUI, K_U, 7'h37, 0, 0);   tset(OP_AUIPC, K_U, 7'h17, 0, 0);
        tset(OP_ADDI, K_I, 7'h13, 0, 0);  tset(OP_XORI, K_I, 7'h13, 4, 0);
        tset(OP_ORI, K_I, 7'h13, 6, 0);   tset(OP_ANDI, K_I, 7'h13, 7, 0);
        tset(OP_SLLI, K_SH, 7'h13, 1, 0); tset(OP_SRLI, K_SH, 7'h13, 5, 0);
        tset(OP_SRAI, K_SH, 7'h13, 5, 7'h20);
        tset(OP_SLTI, K_I, 7'h13, 2, 0);  tset(OP_SLTIU, K_I, 7'h13, 3, 0);
        tset(OP_LB, K_LD, 7'h03, 0, 0);   tset(OP_LH, K_LD, 7'h03, 1, 0);
        tset(OP_LW, K_LD, 7'h03, 2, 0);   tset(OP_LBU, K_LD, 7'h03, 4, 0);
        tset(OP_LHU, K_LD, 7'h03, 5, 0);
        tset(OP_BEQ, K_B, 7'h63, 0, 0);   tset(OP_BNE, K_B, 7'h63, 1, 0);
        tset(OP_BLT, K_B, 7'h63, 4, 0);   tset(OP_BGE, K_B, 7'h63, 5, 0);
        tset(OP_BLTU, K_B, 7'h63, 6, 0);  tset(OP_BGEU, K_B, 7'h63, 7, 0);
        tset(OP_JALR, K_I, 7'h67, 0, 0);
    endtask

    // Reference encoding built from field arithmetic on the instruction formats.
    task automatic model(input req_t r, output logic [31:0] w, output logic [5:0] t, output bit e);
        logic [31:0] imm, rd, rs1, rs2, opc, f3, f7;
        longint      si;
        bit          bad;
        int          k;
        k = kind[r.op]; imm = r.imm; si = longint'($signed(r.imm));
        rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        opc = 32'(t_opc[r.op]); f3 = 32'(t_f3[r.op]); f7 = 32'(t_f7[r.op]);
        w = 0; t = 6'b000000; bad = 0; e = 0;
        case (k)
            K_R: begin w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc; t = 6'b100000; end
            K_I, K_LD: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
                t = (k == K_I) ? 6'b010000 : 6'b000000; bad = (si < -2048) || (si > 2047);
            end
            K_SH: begin
                w = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
                t = 6'b010000; bad = (imm > 31);
            end
            K_S: begin
                w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 31) << 7) | opc;
                t = 6'b001000; bad = (si < -2048) || (si > 2047);
            end
            K_B: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) |
                    (f3 << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | opc;
                t = 6'b000100; bad = (si < -4096) || (si > 4094) || (imm % 2 != 0);
            end
            K_U: begin w = ((imm & 32'hFFFFF) << 12) | (rd << 7) | opc; t = 6'b000001; bad = (imm >> 20) != 0; end
            K_J: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20) |
                    (((imm >> 12) & 255) << 12) | (rd << 7) | opc;
                t = 6'b000010; bad = (si < -1048576) || (si > 1048574) || (imm % 2 != 0);
            end
            default: ;
        endcase
`ifndef IMM_RANGE_CHECK_EN
        bad = 0;
`endif
        if (k == K_ILL || bad) begin w = 0; t = 6'b000000; e = 1; end
    endtask

    task automatic add_req(input op_e op, input int rd, input int rs1, input int rs2, input logic [31:0] imm,
                           input bit has_exp, input logic [31:0] ew, input logic [5:0] et);
        req_t r;
        r.op = 6'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
        r.has_exp = has_exp; r.ew = ew; r.et = et;
        sq.push_back(r);
    endtask

    task automatic add_rand();
        req_t        r;
        logic [31:0] bnd [16];
        bnd = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, 32'd4095, -32'd4096, -32'd4098,
                32'd31, 32'd32, -32'd1, 32'd0, 32'd1048574, -32'd1048576, 32'h000FFFFF, 32'h00100000};
        r.op  = ($urandom_range(9) == 0) ? 6'($urandom_range(63, 38)) : 6'($urandom_range(37));
        r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
        case ($urandom_range(3))
            0: r.imm = 32'($urandom_range(80)) - 32'd40;
            1: r.imm = bnd[$urandom_range(15)];
            2: r.imm = $urandom;
            default: r.imm = 32'($urandom_range(4095)) * 2;
        endcase
        r.has_exp = 0; r.ew = 0; r.et = 0;
        sq.push_back(r);
    endtask

    task automatic drive_req();
        in_op = sq[0].op; in_rd = sq[0].rd; in_rs1 = sq[0].rs1; in_rs2 = sq[0].rs2; in_imm = sq[0].imm;
    endtask

    // Run n words from sq. hold: stall out_ready for that many valid cycles. abort_after: reset after that many outputs.
    task automatic run(input logic [31:0] base, input int n, input int vpct, input int rpct,
                       input int hold, input int abort_after, input bit poke_start);
        int cyc = 0, outs = 0, hold_left = hold, first_hs = -1, last_hs = -1;
        logic [31:0] held_w, held_a;
        bit hs_in, hs_out, e;
        exp_t x;
        @(posedge clock); #1;
        start = 1; base_addr = base; count = 16'(n); cur_base = base; pushed = 0;
        @(posedge clock); #1;
        start = 0;
        if (n == 0) begin
            check("done_count0", done, 1);
            @(posedge clock); #1;
            check("done_pulse0", done, 0);
            return;
        end
        check("busy_run", busy, 1);
        in_valid = (sq.size() > 0) && ($urandom_range(99) < vpct);
        if (sq.size() > 0) drive_req();
        out_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < rpct);
        while (outs < n && cyc < 2000) begin
            @(negedge clock); cyc++;
            hs_in = in_valid && in_ready; hs_out = out_valid && out_ready;
            if (hold_left > 0 && out_valid) begin
                if (hold_left == hold) begin held_w = out_word; held_a = out_addr; end
                check("stall_in_ready", in_ready, 0);
                check("stall_word", out_word, held_w);
                check("stall_addr", out_addr, held_a);
                hold_left--;
            end
            if (hs_out) begin
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    x = sb.pop_front();
                    check("word", out_word, x.w);
                    check("type", out_type, x.t);
                    check("addr", out_addr, x.a);
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc; outs++;
            end
            if (hs_in) begin
                model(sq[0], x.w, x.t, e);
                if (sq[0].has_exp) begin x.w = sq[0].ew; x.t = sq[0].et; end
                x.a = cur_base + 32'(pushed) * 4; pushed++;
                exp_err += int'(e);
                sb.push_back(x);
                void'(sq.pop_front());
            end
            if (abort_after > 0 && outs == abort_after) begin
                reset_n = 0; #1;
                check("rst_out_valid", out_valid, 0); check("rst_out_word", out_word, 0);
                check("rst_out_type", out_type, 0);   check("rst_out_addr", out_addr, 0);
                check("rst_busy", busy, 0);           check("rst_done", done, 0);
                check("rst_err", err_count, 0);       check("rst_in_ready", in_ready, 0);
                exp_err = 0; sb.delete(); sq.delete();
                @(posedge clock); #1;
                reset_n = 1; in_valid = 0; out_ready = 0;
                return;
            end
            @(posedge clock); #1;
            if (outs < n) begin
                in_valid = (sq.size() > 0) && ($urandom_range(99) < vpct);
                if (sq.size() > 0) drive_req();
                out_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < rpct);
                if (poke_start) begin
                    start = ($urandom_range(4) == 0); base_addr = $urandom; count = 16'($urandom_range(9));
                end
            end
        end
        start = 0; in_valid = 0;
        if (cyc >= 2000) check("run_timeout", 0, 1);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("err_count", err_count, 16'(exp_err));
        if (hold > 0) check("back_to_back", last_hs - first_hs, n - 1);
        @(posedge clock); #1;
        check("done_one_cycle", done, 0);
        out_ready = 0;
    endtask

    initial begin
        logic [31:0] w_big;
        logic [5:0]  t_big;
        int          n;
        build_table();
        #23;
        check("reset_out_valid", out_valid, 0); check("reset_out_word", out_word, 0);
        check("reset_out_type", out_type, 0);   check("reset_out_addr", out_addr, 0);
        check("reset_busy", busy, 0);           check("reset_done", done, 0);
        check("reset_err", err_count, 0);       check("reset_in_ready", in_ready, 0);
        @(posedge clock); #1;
        reset_n = 1; in_valid = 1;
        @(negedge clock);
        check("idle_in_ready", in_ready, 0);
        in_valid = 0;

        add_req(OP_ADD, 1, 2, 3, 0, 1, 32'h003100B3, 6'b100000);
        run(32'h100, 1, 100, 100, 0, 0, 0);
        add_req(OP_ADDI, 5, 0, 0, -32'd1, 1, 32'hFFF00293, 6'b010000);
        add_req(OP_SW, 0, 2, 8, 32'd12, 1, 32'h00812623, 6'b001000);
        run(32'h100, 2, 70, 70, 0, 0, 0);
`ifdef IMM_RANGE_CHECK_EN
        w_big = 32'h0; t_big = 6'b000000;
`else
        w_big = 32'h80000013; t_big = 6'b010000;
`endif
        add_req(OP_BEQ, 0, 1, 2, 32'd8, 1, 32'h00208463, 6'b000100);
        add_req(OP_ADDI, 0, 0, 0, 32'd2048, 1, w_big, t_big);
        run(32'h100, 2, 100, 100, 0, 0, 0);
        run(32'h40, 0, 100, 100, 0, 0, 0);

        for (int i = 0; i < 5; i++) add_rand();
        run(32'h2000, 5, 100, 100, 3, 0, 0);

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) add_rand();
            run((r == 3) ? 32'hFFFF_FFF8 : {$urandom_range(65535), 2'b00}, n,
                $urandom_range(100, 40), $urandom_range(100, 40), 0, 0, 1);
        end

        for (int i = 0; i < 4; i++) add_rand();
        run(32'h3000, 4, 100, 100, 0, 2, 0);
        add_req(OP_LUI, 7, 0, 0, 32'h12345, 0, 0, 0);
        run(32'h0, 1, 100, 100, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
